// File: rtl/control_pipe.sv
// control_pipe: pipelined main-control decoder for a 5-stage MIPS pipeline.
// Decodes opcode/funct in ID, carries the control bundle through ID/EX,
// EX/MEM and MEM/WB, detects load-use hazards (stall + bubble), squashes
// the two younger stages on a taken branch and counts illegal opcodes.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   enable                0 forces the ID decode to a bubble
//   instruccion, funcion  IF/ID opcode and funct
//   id_rs, id_rt          IF/ID register specifiers
//   branch_taken          MEM-stage branch resolution
//   jump, stall, flush    combinational PC / IF-ID control
//   ex_*                  ID/EX control register
//   mem_*                 EX/MEM control register
//   wb_*                  MEM/WB control register
//   illegal_cnt           saturating count of illegal opcodes entering ID/EX
module control_pipe #(
    parameter int OPW         = 6,
    parameter int FNW         = 6,
    parameter int REGW        = 5,
    parameter int CNTW        = 8,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [OPW-1:0]  instruccion,
    input  logic [FNW-1:0]  funcion,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            branch_taken,
    output logic            jump,
    output logic            stall,
    output logic            flush,
    output logic            ex_RegDst,
    output logic            ex_ALUSrc,
    output logic            ex_shiftC,
    output logic [1:0]      ex_ALUOp,
    output logic            ex_MemRead,
    output logic            mem_Branch,
    output logic            mem_MemRead,
    output logic            mem_MemWrite,
    output logic            wb_MemtoReg,
    output logic            wb_RegWrite,
    output logic [CNTW-1:0] illegal_cnt
);

    // Opcode / funct encodings
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b001110);
    localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_LH    = OPW'(6'b100001);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_LBU   = OPW'(6'b100100);
    localparam logic [OPW-1:0] OP_LHU   = OPW'(6'b100101);
    localparam logic [OPW-1:0] OP_LWU   = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
    localparam logic [OPW-1:0] OP_SH    = OPW'(6'b101001);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    localparam logic [FNW-1:0] FN_SLL   = FNW'(6'b000000);
    localparam logic [FNW-1:0] FN_SRL   = FNW'(6'b000010);
    localparam logic [FNW-1:0] FN_SRA   = FNW'(6'b000011);

    // Control bundle bit positions
    localparam int B_REGDST   = 0;
    localparam int B_ALUSRC   = 1;
    localparam int B_SHIFTC   = 2;
    localparam int B_ALUOP    = 3;   // two bits: [4:3]
    localparam int B_MEMREAD  = 5;
    localparam int B_MEMWRITE = 6;
    localparam int B_BRANCH   = 7;
    localparam int B_MEMTOREG = 8;
    localparam int B_REGWRITE = 9;
    localparam int BW         = 10;

    // EX/MEM keeps {RegWrite, MemtoReg, Branch, MemWrite, MemRead}
    localparam int M_MEMREAD  = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_BRANCH   = 2;
    localparam int M_MEMTOREG = 3;
    localparam int M_REGWRITE = 4;

    // MEM/WB keeps {RegWrite, MemtoReg}
    localparam int W_MEMTOREG = 0;
    localparam int W_REGWRITE = 1;

    logic [BW-1:0]   dec;
    logic            dec_is_j;
    logic            dec_illegal;
    logic            dec_rt_used;

    logic [BW-1:0]   ex_q,  ex_d;
    logic [REGW-1:0] ex_rt_q, ex_rt_d;
    logic [4:0]      mem_q, mem_d;
    logic [1:0]      wb_q,  wb_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            hazard;
    logic            bubble_id;

    // Raw decode of the opcode in ID; enable is applied later so the
    // hazard check still sees which operand fields the instruction reads.
    always_comb begin
        dec         = '0;
        dec_is_j    = 1'b0;
        dec_illegal = 1'b0;
        dec_rt_used = 1'b0;
        case (instruccion)
            OP_RTYPE: begin
                dec[B_REGDST]          = 1'b1;
                dec[B_REGWRITE]        = 1'b1;
                dec[B_ALUOP +: 2]      = 2'b10;
                dec_rt_used            = 1'b1;
                if (funcion == FN_SLL || funcion == FN_SRL || funcion == FN_SRA)
                    dec[B_SHIFTC] = 1'b1;
            end
            OP_LW, OP_LB, OP_LH, OP_LWU, OP_LBU, OP_LHU: begin
                dec[B_MEMREAD]  = 1'b1;
                dec[B_MEMTOREG] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                dec[B_REGWRITE] = 1'b1;
            end
            OP_SW, OP_SH, OP_SB: begin
                dec[B_MEMWRITE] = 1'b1;
                dec[B_ALUSRC]   = 1'b1;
                dec_rt_used     = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SLTI: begin
                dec[B_ALUSRC]     = 1'b1;
                dec[B_REGWRITE]   = 1'b1;
                dec[B_ALUOP +: 2] = 2'b10;
            end
            OP_BEQ, OP_BNE: begin
                dec[B_BRANCH]     = 1'b1;
                dec[B_ALUOP +: 2] = 2'b01;
                dec_rt_used       = 1'b1;
            end
            OP_J: begin
                dec_is_j = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard against the load currently in EX
    always_comb begin
        hazard = 1'b0;
        if (LOAD_USE_EN && ex_q[B_MEMREAD] && (ex_rt_q != '0)) begin
            if ((ex_rt_q == id_rs) || ((ex_rt_q == id_rt) && dec_rt_used))
                hazard = 1'b1;
        end
    end

    assign stall = hazard & ~branch_taken;
    assign jump  = enable & dec_is_j & ~stall & ~branch_taken;
    assign flush = branch_taken | jump;

    // A J or illegal opcode decodes to an all-zero bundle, so only these
    // three conditions need to force the bubble explicitly.
    assign bubble_id = branch_taken | stall | ~enable;

    always_comb begin
        ex_d    = bubble_id ? '0 : dec;
        ex_rt_d = bubble_id ? '0 : id_rt;

        mem_d   = '0;
        if (!branch_taken) begin
            mem_d[M_MEMREAD]  = ex_q[B_MEMREAD];
            mem_d[M_MEMWRITE] = ex_q[B_MEMWRITE];
            mem_d[M_BRANCH]   = ex_q[B_BRANCH];
            mem_d[M_MEMTOREG] = ex_q[B_MEMTOREG];
            mem_d[M_REGWRITE] = ex_q[B_REGWRITE];
        end

        wb_d[W_MEMTOREG] = mem_q[M_MEMTOREG];
        wb_d[W_REGWRITE] = mem_q[M_REGWRITE];

        cnt_d = cnt_q;
        if (enable && dec_illegal && !bubble_id && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= '0;
            ex_rt_q <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rt_q <= ex_rt_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_RegDst    = ex_q[B_REGDST];
    assign ex_ALUSrc    = ex_q[B_ALUSRC];
    assign ex_shiftC    = ex_q[B_SHIFTC];
    assign ex_ALUOp     = ex_q[B_ALUOP +: 2];
    assign ex_MemRead   = ex_q[B_MEMREAD];
    assign mem_Branch   = mem_q[M_BRANCH];
    assign mem_MemRead  = mem_q[M_MEMREAD];
    assign mem_MemWrite = mem_q[M_MEMWRITE];
    assign wb_MemtoReg  = wb_q[W_MEMTOREG];
    assign wb_RegWrite  = wb_q[W_REGWRITE];
    assign illegal_cnt  = cnt_q;

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the combinational main-control decoder for the 5-stage MIPS pipeline.
- Decodes opcode/funct in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall plus bubble), squashes on taken branch, and counts illegal opcodes.
- Sits beside the datapath pipeline registers; the datapath keeps data fields only.

Parameters:
- OPW, 6, opcode width.
- FNW, 6, funct width.
- REGW, 5, register-specifier width.
- CNTW, 8, illegal-opcode counter width (saturating).
- LOAD_USE_EN, 1, 1 enables load-use stall detection; 0 ties stall to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  0 forces the ID decode to all-zero (bubble).
- instruccion  in  OPW  IF/ID opcode.
- funcion  in  FNW  IF/ID funct.
- id_rs  in  REGW  IF/ID rs.
- id_rt  in  REGW  IF/ID rt.
- branch_taken  in  1  MEM-stage branch resolution (mem_Branch and condition true).
- jump  out  1  combinational ID jump; PC redirect.
- stall  out  1  combinational; hold PC and IF/ID.
- flush  out  1  combinational; clear IF/ID (branch_taken or jump).
- ex_RegDst, ex_ALUSrc, ex_shiftC  out  1 each  ID/EX register.
- ex_ALUOp  out  2  ID/EX register.
- ex_MemRead  out  1  ID/EX register.
- mem_Branch, mem_MemRead, mem_MemWrite  out  1 each  EX/MEM register.
- wb_MemtoReg, wb_RegWrite  out  1 each  MEM/WB register.
- illegal_cnt  out  CNTW  saturating count of illegal opcodes that entered ID/EX.

Behaviour:
- Decode table, identical to the existing Control unit:
  - R-type 000000: RegDst=1, RegWrite=1, ALUOp=10; shiftC=1 for funct 000000/000010/000011.
  - Loads 100011/100000/100001/100111/100100/100101: MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, ALUOp=00.
  - Stores 101011/101001/101000: MemWrite=1, ALUSrc=1, ALUOp=00.
  - Immediates 001100/001101/001110/001000/001010: ALUSrc=1, RegWrite=1, ALUOp=10.
  - BEQ/BNE 000100/000101: Branch=1, ALUOp=01.
  - J 000010: jump=1, all others 0.
  - Any other opcode: all 0, and it counts as illegal.
- ID/EX also captures id_rt internally as ex_rt.
- Reset (reset=0, async): every registered output, ex_rt and illegal_cnt go to 0. Combinational outputs follow inputs and registers.
- Latency: decode of the ID instruction appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Load-use hazard: stall=1 when all of the following hold:
  - LOAD_USE_EN=1;
  - ex_MemRead=1;
  - ex_rt!=0;
  - ex_rt==id_rs, or ex_rt==id_rt with the ID opcode being R-type, store or branch.
- On stall, ID/EX loads the all-zero bundle (bubble). EX/MEM and MEM/WB advance normally. jump is forced to 0 while stall=1.
- branch_taken=1: ID/EX and EX/MEM load zeros (squash the two younger instructions); MEM/WB advances normally; flush=1.
- Priority: branch_taken > stall > normal.
  - stall is forced to 0 while branch_taken=1.
  - Simultaneous jump in ID with branch_taken: the jump is squashed and jump is forced to 0.
- jump=1 (no stall, no branch_taken): flush=1. The J itself enters ID/EX as an all-zero bundle.
- enable=0: ID decode is zero; jump=0; no count. Downstream stages drain normally.
- illegal_cnt: increments on a clock edge where an illegal, enabled, non-stalled, non-squashed opcode is captured into ID/EX. It saturates at 2^CNTW-1 with no wrap.
- Reset asserted mid-operation clears all stages immediately. The first edge after release captures the current ID decode.

Test Plan:
- Reset, then LW (100011) in ID, then ADDI -> ex_MemRead=1 at cycle 1, mem_MemRead=1 at cycle 2, wb_MemtoReg=1 and wb_RegWrite=1 at cycle 3.
- LW with rt=5, then R-type with rs=5 in ID -> stall=1 for exactly 1 cycle, ex_* all 0 on the next cycle, R-type decode appears on ex_* the cycle after (ex_RegDst=1, ex_ALUOp=10).
- LW with rt=0, then R-type with rs=0 -> stall stays 0. Same sequence with LOAD_USE_EN=0 and rt=5 -> stall stays 0.
- BEQ reaches MEM with branch_taken=1 while a LW hazard is pending -> flush=1, stall=0, next-cycle ex_* and mem_* all 0, wb_* carries the older instruction.
- J (000010) in ID -> jump=1 and flush=1 that cycle. J in ID with stall=1 -> jump=0.
- Feed opcode 111111 with CNTW=2 for 5 enabled cycles -> illegal_cnt reads 1,2,3,3,3. With enable=0 -> no increment. Assert reset mid-run -> all outputs 0 immediately.
